// File: rtl/pmem_arbiter.sv
// Round-robin arbiter that funnels per-core program fetches onto a single
// program-cache port, using four-phase valid/ready handshakes on both sides.
module pmem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data    [NUM_CONSUMERS],
    output logic                     cache_read_valid,
    output logic [ADDR_BITS-1:0]     cache_read_address,
    input  logic                     cache_read_ready,
    input  logic [DATA_BITS-1:0]     cache_read_data
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RELAY,
        DRAIN
    } state_e;

    state_e                     state_q;
    logic [IDX_BITS-1:0]        rr_ptr_q;
    logic [IDX_BITS-1:0]        grant_q;
    logic                       cache_valid_q;
    logic [ADDR_BITS-1:0]       cache_addr_q;
    logic [NUM_CONSUMERS-1:0]   cons_ready_q;
    logic [DATA_BITS-1:0]       cons_data_q [NUM_CONSUMERS];

    logic                       grant_found_d;
    logic [IDX_BITS-1:0]        grant_d;
    logic [IDX_BITS-1:0]        rr_ptr_d;

    // Scan requesters starting at rr_ptr; the first hit wins and the pointer
    // moves just past it so the winner becomes lowest priority next time.
    always_comb begin
        int unsigned idx;
        idx           = 0;
        grant_found_d = 1'b0;
        grant_d       = '0;
        rr_ptr_d      = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_CONSUMERS;
            if (!grant_found_d && consumer_read_valid[IDX_BITS'(idx)]) begin
                grant_found_d = 1'b1;
                grant_d       = IDX_BITS'(idx);
                rr_ptr_d      = IDX_BITS'((idx + 1) % NUM_CONSUMERS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cons_ready_q  <= '0;
            for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
                cons_data_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_found_d) begin
                        cache_addr_q  <= consumer_read_address[grant_d];
                        cache_valid_q <= 1'b1;
                        grant_q       <= grant_d;
                        rr_ptr_q      <= rr_ptr_d;
                        state_q       <= REQUEST;
                    end
                end
                REQUEST: begin
                    // Completes even if the consumer already dropped valid.
                    if (cache_read_ready) begin
                        cache_valid_q         <= 1'b0;
                        cons_ready_q[grant_q] <= 1'b1;
                        cons_data_q[grant_q]  <= cache_read_data;
                        state_q               <= RELAY;
                    end
                end
                RELAY: begin
                    if (!consumer_read_valid[grant_q]) begin
                        cons_ready_q[grant_q] <= 1'b0;
                        cons_data_q[grant_q]  <= '0;
                        state_q               <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!cache_read_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cache_read_valid    = cache_valid_q;
    assign cache_read_address  = cache_addr_q;
    assign consumer_read_ready = cons_ready_q;
    assign consumer_read_data  = cons_data_q;

    a_one_ready: assert property (@(posedge clk) disable iff (reset) $onehot0(cons_ready_q));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboarded bench for pmem_arbiter: consumer agents and a cache responder
// drive the handshakes, a monitor checks every DUT event against a queue.
module tb_pmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NC = 2;

    typedef struct {
        bit          is_cons;
        int          idx;
        logic [15:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NC-1:0] cons_valid = '0;
    logic [AW-1:0] cons_addr [NC];
    logic [NC-1:0] cons_ready;
    logic [DW-1:0] cons_data [NC];
    logic          cache_valid;
    logic [AW-1:0] cache_addr;
    logic          cache_ready = 1'b0;
    logic [DW-1:0] cache_data = '0;

    int total = 0;
    int bad   = 0;

    exp_t          exp_q [$];
    logic [AW-1:0] pend0 [$];
    logic [AW-1:0] pend1 [$];
    logic [NC-1:0] busy = '0;
    int            lat = 2;
    int            hold_extra = 0;
    logic          rdy_at_edge = 1'b0;

    pmem_arbiter #(
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW),
        .NUM_CONSUMERS (NC)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (cons_valid),
        .consumer_read_address (cons_addr),
        .consumer_read_ready   (cons_ready),
        .consumer_read_data    (cons_data),
        .cache_read_valid      (cache_valid),
        .cache_read_address    (cache_addr),
        .cache_read_ready      (cache_ready),
        .cache_read_data       (cache_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] resp_word(input logic [AW-1:0] a);
        if (a == 8'h2A) return 16'hBEEF;
        return {~a, a};
    endfunction

    function automatic void exp_cache(input logic [AW-1:0] a);
        exp_t e;
        e.is_cons = 1'b0; e.idx = 0; e.val = {8'h00, a};
        exp_q.push_back(e);
    endfunction

    function automatic void exp_cons(input int c, input logic [DW-1:0] d);
        exp_t e;
        e.is_cons = 1'b1; e.idx = c; e.val = d;
        exp_q.push_back(e);
    endfunction

    function automatic void pend_push(input int c, input logic [AW-1:0] a);
        if (c == 0) pend0.push_back(a); else pend1.push_back(a);
    endfunction

    function automatic int pend_size(input int c);
        return (c == 0) ? pend0.size() : pend1.size();
    endfunction

    function automatic logic [AW-1:0] pend_pop(input int c);
        if (c == 0) return pend0.pop_front();
        return pend1.pop_front();
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    task automatic sb_pop(input bit is_cons, input int idx, input logic [15:0] val);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected got kind=%0d idx=%0d val=%h expected=none", is_cons, idx, val);
        end else begin
            e = exp_q.pop_front();
            if (e.is_cons !== is_cons || e.idx != idx || e.val !== val) begin
                bad++;
                $display("FAIL sb_event got kind=%0d idx=%0d val=%h expected kind=%0d idx=%0d val=%h",
                         is_cons, idx, val, e.is_cons, e.idx, e.val);
            end
        end
    endtask

    // Consumer agents: raise valid with the next queued address, drop it when
    // ready is seen, and start the next request once ready has fallen.
    initial begin
        cons_addr[0] = '0;
        cons_addr[1] = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                if (!busy[c]) begin
                    if (pend_size(c) > 0) begin
                        cons_addr[c]  = pend_pop(c);
                        cons_valid[c] = 1'b1;
                        busy[c]       = 1'b1;
                    end
                end else if (cons_valid[c]) begin
                    if (cons_ready[c] === 1'b1) cons_valid[c] = 1'b0;
                end else if (cons_ready[c] === 1'b0) begin
                    busy[c] = 1'b0;
                end
            end
        end
    end

    // Cache responder with programmable answer latency and ready hold time.
    initial begin
        int cnt;
        int hcnt;
        cnt = 0;
        hcnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cache_ready = 1'b0;
                cache_data  = '0;
                cnt = 0;
                hcnt = 0;
            end else if (!cache_ready) begin
                if (cache_valid === 1'b1) begin
                    cnt++;
                    if (cnt >= lat) begin
                        cache_ready = 1'b1;
                        cache_data  = resp_word(cache_addr);
                        cnt = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end else if (cache_valid === 1'b0) begin
                if (hcnt >= hold_extra) begin
                    cache_ready = 1'b0;
                    hcnt = 0;
                end else begin
                    hcnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            rdy_at_edge = cache_ready;
        end
    end

    // Monitor: pops the scoreboard on every rising valid/ready and checks
    // per-cycle invariants of the consumer and cache ports.
    initial begin
        logic          prev_cv;
        logic [NC-1:0] prev_rdy;
        logic [AW-1:0] cur_addr;
        prev_cv  = 1'b0;
        prev_rdy = '0;
        cur_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (cache_valid === 1'b1 && !prev_cv) begin
                    cur_addr = cache_addr;
                    sb_pop(1'b0, 0, {8'h00, cache_addr});
                    check("grant_while_cache_ready", {31'd0, rdy_at_edge}, 32'd0);
                end
                for (int c = 0; c < NC; c++) begin
                    if (cons_ready[c] === 1'b1 && !prev_rdy[c]) sb_pop(1'b1, c, cons_data[c]);
                end
                check("ready_onehot0", {31'd0, $onehot0(cons_ready)}, 32'd1);
                for (int c = 0; c < NC; c++) begin
                    if (cons_ready[c] !== 1'b1) check("idle_consumer_data", {16'd0, cons_data[c]}, 32'd0);
                end
                if (cache_valid === 1'b1 || cache_ready) begin
                    check("cache_addr_stable", {24'd0, cache_addr}, {24'd0, cur_addr});
                end
            end
            prev_cv  = (cache_valid === 1'b1);
            prev_rdy = cons_ready;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        lat = 2;
        hold_extra = 0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("rst_cache_valid", {31'd0, cache_valid}, 32'd0);
        check("rst_cache_addr", {24'd0, cache_addr}, 32'd0);
        check("rst_cons_ready", {30'd0, cons_ready}, 32'd0);
        check("rst_cons_data0", {16'd0, cons_data[0]}, 32'd0);
        check("rst_cons_data1", {16'd0, cons_data[1]}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy != '0 || cache_ready || pend0.size() != 0 || pend1.size() != 0)
               && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL %s_timeout got pending=%0d expected pending=0", name, exp_q.size());
            exp_q.delete();
            pend0.delete();
            pend1.delete();
            busy = '0;
            cons_valid = '0;
        end
    endtask

    task automatic wait_cv(input string name);
        int n;
        n = 0;
        while (cache_valid !== 1'b1 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, "_cache_valid_seen"}, {31'd0, cache_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Single fetch from consumer 1.
        lat = 3;
        exp_cache(8'h2A);
        exp_cons(1, 16'hBEEF);
        pend_push(1, 8'h2A);
        @(negedge clk); #1;
        check("t1_no_early_grant", {31'd0, cache_valid}, 32'd0);
        @(negedge clk); #1;
        check("t1_grant_latency", {31'd0, cache_valid}, 32'd1);
        check("t1_cache_addr", {24'd0, cache_addr}, 32'h2A);
        wait_done("t1");

        // Contention: simultaneous requests, then a repeat.
        do_reset();
        exp_cache(8'h01); exp_cons(0, 16'hFE01);
        exp_cache(8'h02); exp_cons(1, 16'hFD02);
        pend_push(0, 8'h01);
        pend_push(1, 8'h02);
        wait_done("t2a");
        exp_cache(8'h03); exp_cons(0, 16'hFC03);
        exp_cache(8'h04); exp_cons(1, 16'hFB04);
        pend_push(0, 8'h03);
        pend_push(1, 8'h04);
        wait_done("t2b");

        // Fairness: grants alternate while both keep requesting.
        do_reset();
        exp_cache(8'h40); exp_cons(0, 16'hBF40);
        exp_cache(8'h50); exp_cons(1, 16'hAF50);
        exp_cache(8'h41); exp_cons(0, 16'hBE41);
        exp_cache(8'h51); exp_cons(1, 16'hAE51);
        pend_push(0, 8'h40);
        pend_push(0, 8'h41);
        pend_push(1, 8'h50);
        pend_push(1, 8'h51);
        wait_done("t3");

        // Slow release: cache holds ready after valid falls.
        do_reset();
        hold_extra = 4;
        exp_cache(8'h60); exp_cons(0, 16'h9F60);
        exp_cache(8'h61); exp_cons(1, 16'h9E61);
        pend_push(0, 8'h60);
        wait_cv("t4");
        pend_push(1, 8'h61);
        for (int n = 0; n < 20 && cons_ready[0] !== 1'b1; n++) begin
            @(negedge clk); #1;
        end
        check("t4_cons0_ready", {31'd0, cons_ready[0]}, 32'd1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            if (!cache_ready) break;
            check("t4_no_regrant_in_drain", {31'd0, cache_valid}, 32'd0);
        end
        wait_done("t4");

        // Address stability: consumer changes its address during REQUEST.
        do_reset();
        lat = 4;
        exp_cache(8'h10); exp_cons(0, 16'hEF10);
        pend_push(0, 8'h10);
        wait_cv("t5");
        cons_addr[0] = 8'h20;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("t5_addr_hold", {24'd0, cache_addr}, 32'h10);
        wait_done("t5");

        // Reset in REQUEST, with a second requester waiting.
        do_reset();
        lat = 6;
        exp_cache(8'h30);
        pend_push(0, 8'h30);
        wait_cv("t6");
        pend_push(1, 8'h31);
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        check("t6_rst_cache_valid", {31'd0, cache_valid}, 32'd0);
        check("t6_rst_cache_addr", {24'd0, cache_addr}, 32'd0);
        check("t6_rst_cons_ready", {30'd0, cons_ready}, 32'd0);
        check("t6_rst_cons_data0", {16'd0, cons_data[0]}, 32'd0);
        check("t6_rst_cons_data1", {16'd0, cons_data[1]}, 32'd0);
        exp_cache(8'h30); exp_cons(0, 16'hCF30);
        exp_cache(8'h31); exp_cons(1, 16'hCE31);
        reset = 1'b0;
        wait_done("t6");

        check("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
